uart_cmd_bus_master: RTL

//  Command parser between UART RX/TX byte streams and the uart_* bus of the SRAM bridge.

---
 rtl/uart_cmd_bus_master.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/uart_cmd_bus_master.sv
// rtl/uart_cmd_bus_master.sv - UART command parser driving single bus cycles on the SRAM bridge
//
// Purpose: decodes framed commands from the UART RX byte stream into one bus
// access each. 'W' AH AL D writes D to {AH,AL}. 'R' AH AL reads {AH,AL} and
// returns the data as one TX byte. Bytes that are not a command byte are
// ignored while idle, which lets the parser resynchronise to the frame boundary.
//
// Ports:
//   clk50_dup        in   system clock
//   rst              in   asynchronous reset, active-high
//   rx_data[7:0]     in   received UART byte
//   rx_valid         in   1-cycle strobe, rx_data valid
//   tx_data[7:0]     out  reply byte, stable while tx_valid
//   tx_valid         out  reply byte valid, held until tx_ready
//   tx_ready         in   transmitter accepts tx_data
//   uart_address     out  bus address (register)
//   uart_write_data  out  bus write data (register)
//   uart_read_data   in   bus read data, READ_LATENCY cycles after grant
//   uart_write       out  bus write strobe
//   uart_read        out  bus read strobe
//   uart_req         out  bus access request
//   uart_gnt         in   bus grant
//   rx_drop          out  pulse, rx byte discarded while a command executes
//   cmd_timeout      out  pulse, partial command abandoned after TIMEOUT idle cycles

module uart_cmd_bus_master #(
  parameter int READ_LATENCY = 2,
  parameter int RL_W         = 2,
  parameter int TIMEOUT      = 50000,
  parameter int TIMEOUT_W    = 16
) (
  input  logic        clk50_dup,
  input  logic        rst,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic [15:0] uart_address,
  output logic [7:0]  uart_write_data,
  input  logic [7:0]  uart_read_data,
  output logic        uart_write,
  output logic        uart_read,
  output logic        uart_req,
  input  logic        uart_gnt,
  output logic        rx_drop,
  output logic        cmd_timeout
);

  localparam logic [7:0] CMD_WRITE = 8'h57;
  localparam logic [7:0] CMD_READ  = 8'h52;

  typedef enum logic [2:0] {
    S_IDLE, S_ADDR_H, S_ADDR_L, S_DATA, S_BUS_WR, S_BUS_RD, S_RD_WAIT, S_TX
  } state_t;

  state_t               r_state;
  logic                 r_is_wr;
  logic [TIMEOUT_W-1:0] r_to_cnt;
  logic [RL_W-1:0]      r_rl_cnt;
  logic [15:0]          r_addr;
  logic [7:0]           r_wdata;
  logic [7:0]           r_tx_data;

  logic w_in_cmd;
  logic w_busy;
  logic w_to_expire;

  // States that are collecting bytes of a frame and therefore run the timeout.
  assign w_in_cmd = (r_state == S_ADDR_H) || (r_state == S_ADDR_L) || (r_state == S_DATA);
  // States that cannot accept a byte: a bus cycle or reply is in flight.
  assign w_busy   = (r_state == S_BUS_WR) || (r_state == S_BUS_RD) ||
                    (r_state == S_RD_WAIT) || (r_state == S_TX);
  // A byte in the expiry cycle takes priority over the timeout.
  assign w_to_expire = w_in_cmd && !rx_valid && (r_to_cnt == TIMEOUT_W'(TIMEOUT - 1));

  // Bus strobes and tx_valid are decoded straight from the state register so
  // they can never be asserted outside their own states.
  assign uart_req        = (r_state == S_BUS_WR) || (r_state == S_BUS_RD);
  assign uart_write      = (r_state == S_BUS_WR);
  assign uart_read       = (r_state == S_BUS_RD);
  assign tx_valid        = (r_state == S_TX);
  assign rx_drop         = rx_valid && w_busy;
  assign cmd_timeout     = w_to_expire;
  assign uart_address    = r_addr;
  assign uart_write_data = r_wdata;
  assign tx_data         = r_tx_data;

  always_ff @(posedge clk50_dup or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_is_wr   <= 1'b0;
      r_to_cnt  <= '0;
      r_rl_cnt  <= '0;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_tx_data <= '0;
    end else begin
      // Counter restarts on every accepted byte, so each gap is timed separately.
      if (w_in_cmd && !rx_valid && !w_to_expire) begin
        r_to_cnt <= r_to_cnt + 1'b1;
      end else begin
        r_to_cnt <= '0;
      end

      case (r_state)
        S_IDLE: begin
          if (rx_valid && rx_data == CMD_WRITE) begin
            r_is_wr <= 1'b1;
            r_state <= S_ADDR_H;
          end else if (rx_valid && rx_data == CMD_READ) begin
            r_is_wr <= 1'b0;
            r_state <= S_ADDR_H;
          end
        end
        S_ADDR_H: begin
          if (rx_valid) begin
            r_addr[15:8] <= rx_data;
            r_state      <= S_ADDR_L;
          end else if (w_to_expire) begin
            r_state <= S_IDLE;
          end
        end
        S_ADDR_L: begin
          if (rx_valid) begin
            r_addr[7:0] <= rx_data;
            r_state     <= r_is_wr ? S_DATA : S_BUS_RD;
          end else if (w_to_expire) begin
            r_state <= S_IDLE;
          end
        end
        S_DATA: begin
          if (rx_valid) begin
            r_wdata <= rx_data;
            r_state <= S_BUS_WR;
          end else if (w_to_expire) begin
            r_state <= S_IDLE;
          end
        end
        S_BUS_WR: begin
          if (uart_gnt) r_state <= S_IDLE;
        end
        S_BUS_RD: begin
          if (uart_gnt) begin
            r_rl_cnt <= '0;
            r_state  <= S_RD_WAIT;
          end
        end
        S_RD_WAIT: begin
          if (r_rl_cnt == RL_W'(READ_LATENCY - 1)) begin
            r_tx_data <= uart_read_data;
            r_state   <= S_TX;
          end else begin
            r_rl_cnt <= r_rl_cnt + 1'b1;
          end
        end
        S_TX: begin
          if (tx_ready) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
